mem_dump: RTL

//  Bus reader that streams a block of RAM out of the SoC after boot/run.

---
 rtl/mem_dump.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_dump.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_dump                                                     |
// | Description : Bus-mastering RAM reader. Requests the shared addr/data bus  |
// |               from the CPU, reads a block of words starting at base_addr   |
// |               and streams them out on a valid/ready interface.             |
// |               Optional feature macro: MEM_DUMP_CSUM_EN (appends a          |
// |               two's-complement checksum word so the stream sums to zero).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module mem_dump #(
    parameter int RD_LAT    = 1,
    parameter int ADDR_SIZE = `ADDR_SIZE,
    parameter int WORD_SIZE = `WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] base_addr,
    input  logic [ADDR_SIZE-1:0] length,
    output logic                 bus_req,
    input  logic                 bus_gnt,
    output logic [ADDR_SIZE-1:0] addr_out,
    output logic                 addr_oe,
    output logic                 wr_en,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    // State encoding
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_REQ  = 3'd1;
    localparam logic [2:0] c_ST_ADDR = 3'd2;
    localparam logic [2:0] c_ST_SEND = 3'd3;
    localparam logic [2:0] c_ST_CSUM = 3'd4;
    localparam logic [2:0] c_ST_FIN  = 3'd5;

    // Read latency counter: RD_LAT is limited to 1..4, so two bits suffice
    localparam logic [1:0]           c_LAT_LAST = 2'(RD_LAT - 1);
    localparam logic [ADDR_SIZE-1:0] c_A_ZERO   = '0;
    localparam logic [ADDR_SIZE-1:0] c_A_ONE    = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

    logic [2:0]           r_state;
    logic [ADDR_SIZE-1:0] r_cur;
    logic [ADDR_SIZE-1:0] r_rem;
    logic [1:0]           r_lat_cnt;
    logic [ADDR_SIZE-1:0] r_addr_out;
    logic                 r_addr_oe;
    logic                 r_bus_req;
    logic [WORD_SIZE-1:0] r_out_data;
    logic                 r_out_valid;
    logic                 r_out_last;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_handshake;
    logic                 w_last_word;
    logic [ADDR_SIZE-1:0] w_next_addr;

`ifdef MEM_DUMP_CSUM_EN
    localparam logic [WORD_SIZE-1:0] c_W_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

    logic [WORD_SIZE-1:0] r_sum;
    logic [WORD_SIZE-1:0] w_sum_next;
    logic [WORD_SIZE-1:0] w_csum;

    // Sum including the word being handed off, and its negation for the trailer
    assign w_sum_next = r_sum + r_out_data;
    assign w_csum     = ~w_sum_next + c_W_ONE;
`endif

    assign w_handshake = r_out_valid & out_ready;
    assign w_last_word = (r_rem == c_A_ONE);
    assign w_next_addr = r_cur + c_A_ONE;

    // Outputs; addr_oe is gated by the live grant so the bus is released the
    // same cycle the CPU takes it back
    assign bus_req   = r_bus_req;
    assign addr_out  = r_addr_out;
    assign addr_oe   = r_addr_oe & bus_gnt;
    assign wr_en     = 1'b0;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

    // Dump sequencer: bus arbitration, address issue, data capture and stream handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cur       <= '0;
            r_rem       <= '0;
            r_lat_cnt   <= '0;
            r_addr_out  <= '0;
            r_addr_oe   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef MEM_DUMP_CSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
`ifdef MEM_DUMP_CSUM_EN
                        r_sum <= '0;
`endif
                        if (length != c_A_ZERO) begin
                            r_cur     <= base_addr;
                            r_rem     <= length;
                            r_busy    <= 1'b1;
                            r_bus_req <= 1'b1;
                            r_state   <= c_ST_REQ;
                        end else begin
`ifdef MEM_DUMP_CSUM_EN
                            // Empty block still yields its (zero) checksum word
                            r_out_data  <= '0;
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= c_ST_CSUM;
`else
                            r_done  <= 1'b1;
                            r_state <= c_ST_FIN;
`endif
                        end
                    end
                end

                c_ST_REQ: begin
                    if (bus_gnt) begin
                        r_addr_oe  <= 1'b1;
                        r_addr_out <= r_cur;
                        r_lat_cnt  <= '0;
                        r_state    <= c_ST_ADDR;
                    end
                end

                c_ST_ADDR: begin
                    if (!bus_gnt) begin
                        // Grant lost before capture: retry the same address
                        r_addr_oe <= 1'b0;
                        r_state   <= c_ST_REQ;
                    end else if (r_lat_cnt == c_LAT_LAST) begin
                        r_out_data  <= data_in;
                        r_out_valid <= 1'b1;
`ifdef MEM_DUMP_CSUM_EN
                        r_out_last  <= 1'b0;
`else
                        r_out_last  <= w_last_word;
`endif
                        r_addr_oe   <= 1'b0;
                        r_state     <= c_ST_SEND;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end

                c_ST_SEND: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_cur       <= w_next_addr;
                        r_rem       <= r_rem - c_A_ONE;
`ifdef MEM_DUMP_CSUM_EN
                        r_sum       <= w_sum_next;
`endif
                        if (w_last_word) begin
                            r_bus_req <= 1'b0;
`ifdef MEM_DUMP_CSUM_EN
                            r_out_data  <= w_csum;
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b1;
                            r_state     <= c_ST_CSUM;
`else
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= c_ST_FIN;
`endif
                        end else begin
                            r_addr_oe  <= 1'b1;
                            r_addr_out <= w_next_addr;
                            r_lat_cnt  <= '0;
                            r_state    <= c_ST_ADDR;
                        end
                    end
                end

                c_ST_CSUM: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= c_ST_FIN;
                    end
                end

                c_ST_FIN: begin
                    // done is visible for exactly this cycle
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
